// File: rtl/mux_serial_sequencer.sv
// rtl/mux_serial_sequencer.sv - word loader and select sequencer driving a 16:1 mux as a parallel-to-serial converter
//
// Purpose: accepts a 16-bit word over a valid/ready handshake, holds it on the
// mux data inputs (d) and walks the mux select (s) across all 16 positions,
// forwarding the mux output y as one beat per position on a serial
// valid/ready stream with a last-beat marker.
//
// Configuration macro: MSB_FIRST_EN
//   defined   - s counts 15 down to 0 (MSB-first), ser_last at s == 0
//   undefined - s counts 0 up to 15 (LSB-first), ser_last at s == 15
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   load_valid in   upstream word available
//   load_ready out  word can be accepted this cycle
//   load_data  in   word to serialise
//   d          out  registered word, drives mux d
//   s          out  registered select, drives mux s
//   y          in   mux output d[s]
//   ser_valid  out  serial beat valid
//   ser_ready  in   downstream accepts beat
//   ser_data   out  serial bit (y, combinational pass-through)
//   ser_last   out  current beat is the last of the word
//   busy       out  high while shifting a word

module mux_serial_sequencer #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] d,
  output logic [SEL_W-1:0] s,
  input  logic             y,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy
);

`ifdef MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST_IDX = '1;
  localparam logic [SEL_W-1:0] LAST_IDX  = '0;
`else
  localparam logic [SEL_W-1:0] FIRST_IDX = '0;
  localparam logic [SEL_W-1:0] LAST_IDX  = '1;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [SEL_W-1:0] s_q, s_d;

  logic shifting;
  logic at_last;
  logic beat_xfer;

  assign shifting  = (state_q == SHIFT);
  assign at_last   = (s_q == LAST_IDX);
  // ser_valid is high for the whole SHIFT state, so a transfer is just ready.
  assign beat_xfer = shifting && ser_ready;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    s_d     = s_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          d_d     = load_data;
          s_d     = FIRST_IDX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat_xfer) begin
          if (!at_last) begin
`ifdef MSB_FIRST_EN
            s_d = s_q - SEL_W'(1);
`else
            s_d = s_q + SEL_W'(1);
`endif
          end else if (load_valid) begin
            // Back-to-back word: reload on the last beat, no idle bubble.
            d_d = load_data;
            s_d = FIRST_IDX;
          end else begin
            // d keeps the finished word; only the select rewinds.
            s_d     = FIRST_IDX;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      s_q     <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      s_q     <= s_d;
    end
  end

  assign d          = d_q;
  assign s          = s_q;
  assign ser_valid  = shifting;
  assign busy       = shifting;
  assign ser_last   = shifting && at_last;
  assign ser_data   = y;
  // Ready on the last beat only when that beat actually leaves this cycle.
  assign load_ready = !shifting || (at_last && ser_ready);

endmodule

// File: tb/tb_mux_serial_sequencer.sv
// tb/tb_mux_serial_sequencer.sv - directed self-checking bench for mux_serial_sequencer

module tb_mux_serial_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [15:0] d;
  logic [3:0]  s;
  logic        y;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_data;
  logic        ser_last;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

`ifdef MSB_FIRST_EN
  localparam logic [3:0] FIRST_S = 4'd15;
`else
  localparam logic [3:0] FIRST_S = 4'd0;
`endif

  always #5 clk = ~clk;

  // Behavioural stand-in for the 16:1 select-tree mux.
  assign y = d[s];

  mux_serial_sequencer #(.WIDTH(16), .SEL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .d          (d),
    .s          (s),
    .y          (y),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_data   (ser_data),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  task automatic test_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'hFFFF;
    ser_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (d !== 16'h0000) begin miscompares++; $display("FAIL reset_d c=%0d got %h exp 0000", c, d); end
      vectors++;
      if (s !== FIRST_S) begin miscompares++; $display("FAIL reset_s c=%0d got %0d exp %0d", c, s, FIRST_S); end
      vectors++;
      if (ser_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ser_valid c=%0d got %b exp 0", c, ser_valid); end
      vectors++;
      if (load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_load_ready c=%0d got %b exp 1", c, load_ready); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy c=%0d got %b exp 0", c, busy); end
    end
  endtask

`ifndef MSB_FIRST_EN
  task automatic test_single_word();
    int exp_bits [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    ser_ready  = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'hA5C3;
    vectors++;
    if (load_ready !== 1'b1) begin miscompares++; $display("FAIL single_load_ready got %b exp 1", load_ready); end
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 16'h5A5A;
    for (int b = 0; b < 16; b++) begin
      vectors++;
      if (ser_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid beat=%0d got %b exp 1", b, ser_valid); end
      vectors++;
      if (s !== 4'(b)) begin miscompares++; $display("FAIL single_s beat=%0d got %0d exp %0d", b, s, b); end
      vectors++;
      if (ser_data !== exp_bits[b][0]) begin miscompares++; $display("FAIL single_data beat=%0d got %b exp %0d", b, ser_data, exp_bits[b]); end
      vectors++;
      if (ser_last !== (b == 15)) begin miscompares++; $display("FAIL single_last beat=%0d got %b exp %b", b, ser_last, (b == 15)); end
      @(negedge clk);
    end
    vectors++;
    if (ser_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_idle got valid=%b busy=%b exp 0 0", ser_valid, busy); end
    vectors++;
    if (d !== 16'hA5C3 || s !== 4'd0) begin miscompares++; $display("FAIL single_hold got d=%h s=%0d exp a5c3 0", d, s); end
  endtask

  task automatic test_backpressure();
    int beat  = 0;
    int stall = 0;
    ser_ready  = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h8001;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 16'hFFFF;
    for (int c = 0; c < 40 && beat < 16; c++) begin
      if (beat == 1 && stall < 3) begin
        ser_ready = 1'b0;
        stall++;
      end else begin
        ser_ready = 1'b1;
      end
      #1;
      vectors++;
      if (ser_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid beat=%0d got %b exp 1", beat, ser_valid); end
      vectors++;
      if (s !== 4'(beat)) begin miscompares++; $display("FAIL bp_s beat=%0d got %0d exp %0d", beat, s, beat); end
      vectors++;
      if (d !== 16'h8001) begin miscompares++; $display("FAIL bp_d beat=%0d got %h exp 8001", beat, d); end
      vectors++;
      if (ser_data !== ((beat == 0) || (beat == 15))) begin miscompares++; $display("FAIL bp_data beat=%0d got %b exp %b", beat, ser_data, ((beat == 0) || (beat == 15))); end
      vectors++;
      if (ser_last !== (beat == 15)) begin miscompares++; $display("FAIL bp_last beat=%0d got %b exp %b", beat, ser_last, (beat == 15)); end
      if (!ser_ready) begin
        vectors++;
        if (load_ready !== 1'b0) begin miscompares++; $display("FAIL bp_load_ready_stall got %b exp 0", load_ready); end
      end
      if (ser_ready) beat++;
      @(negedge clk);
    end
    ser_ready = 1'b1;
    vectors++;
    if (beat != 16 || stall != 3) begin miscompares++; $display("FAIL bp_count got beats=%0d stalls=%0d exp 16 3", beat, stall); end
    vectors++;
    if (ser_valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle got %b exp 0", ser_valid); end
  endtask

  task automatic test_back_to_back();
    ser_ready  = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    @(negedge clk);
    load_data = 16'h0000;
    for (int b = 0; b < 32; b++) begin
      if (b == 16) load_valid = 1'b0;
      #1;
      vectors++;
      if (ser_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid beat=%0d got %b exp 1", b, ser_valid); end
      vectors++;
      if (ser_data !== (b < 16)) begin miscompares++; $display("FAIL b2b_data beat=%0d got %b exp %b", b, ser_data, (b < 16)); end
      vectors++;
      if (s !== 4'(b % 16)) begin miscompares++; $display("FAIL b2b_s beat=%0d got %0d exp %0d", b, s, b % 16); end
      vectors++;
      if (ser_last !== ((b % 16) == 15)) begin miscompares++; $display("FAIL b2b_last beat=%0d got %b exp %b", b, ser_last, ((b % 16) == 15)); end
      vectors++;
      if (load_ready !== ((b % 16) == 15)) begin miscompares++; $display("FAIL b2b_load_ready beat=%0d got %b exp %b", b, load_ready, ((b % 16) == 15)); end
      @(negedge clk);
    end
    vectors++;
    if (ser_valid !== 1'b0 || d !== 16'h0000) begin miscompares++; $display("FAIL b2b_idle got valid=%b d=%h exp 0 0000", ser_valid, d); end
  endtask

  task automatic test_reset_mid_word();
    ser_ready  = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h1234;
    @(negedge clk);
    load_valid = 1'b0;
    for (int b = 0; b < 5; b++) begin
      vectors++;
      if (ser_data !== ((16'h1234 >> b) & 16'h1) || s !== 4'(b)) begin miscompares++; $display("FAIL rmw_pre beat=%0d got data=%b s=%0d exp s=%0d", b, ser_data, s, b); end
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (ser_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmw_async got valid=%b busy=%b exp 0 0", ser_valid, busy); end
    vectors++;
    if (d !== 16'h0000 || s !== 4'd0) begin miscompares++; $display("FAIL rmw_regs got d=%h s=%0d exp 0000 0", d, s); end
    vectors++;
    if (load_ready !== 1'b1) begin miscompares++; $display("FAIL rmw_load_ready got %b exp 1", load_ready); end
    @(negedge clk);
    rst        = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'h0001;
    @(negedge clk);
    load_valid = 1'b0;
    for (int b = 0; b < 16; b++) begin
      vectors++;
      if (ser_valid !== 1'b1 || s !== 4'(b)) begin miscompares++; $display("FAIL rmw_restart_s beat=%0d got valid=%b s=%0d exp 1 %0d", b, ser_valid, s, b); end
      vectors++;
      if (ser_data !== (b == 0)) begin miscompares++; $display("FAIL rmw_restart_data beat=%0d got %b exp %b", b, ser_data, (b == 0)); end
      @(negedge clk);
    end
    vectors++;
    if (ser_valid !== 1'b0) begin miscompares++; $display("FAIL rmw_end got %b exp 0", ser_valid); end
  endtask
`else
  task automatic test_msb_first();
    ser_ready  = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h8000;
    @(negedge clk);
    load_valid = 1'b0;
    for (int b = 0; b < 16; b++) begin
      vectors++;
      if (ser_valid !== 1'b1 || s !== 4'(15 - b)) begin miscompares++; $display("FAIL msb_s beat=%0d got valid=%b s=%0d exp 1 %0d", b, ser_valid, s, 15 - b); end
      vectors++;
      if (ser_data !== (b == 0)) begin miscompares++; $display("FAIL msb_data beat=%0d got %b exp %b", b, ser_data, (b == 0)); end
      vectors++;
      if (ser_last !== (b == 15)) begin miscompares++; $display("FAIL msb_last beat=%0d got %b exp %b", b, ser_last, (b == 15)); end
      @(negedge clk);
    end
    vectors++;
    if (ser_valid !== 1'b0 || s !== 4'd15) begin miscompares++; $display("FAIL msb_idle got valid=%b s=%0d exp 0 15", ser_valid, s); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef MSB_FIRST_EN
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
`else
    test_msb_first();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
